axi_lite_reg_master: RTL

AXI_LITE_REG_MASTER -- requirements
Module: axi_lite_reg_master

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_lite_reg_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register master.
// Response codes follow the AXI encoding; RESP_TIMEOUT deliberately reuses
// the DECERR code, so a timeout and a decode error look alike to the user.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_e;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY    = 2'b00;
    localparam resp_t RESP_SLVERR  = 2'b10;
    localparam resp_t RESP_DECERR  = 2'b11;
    localparam resp_t RESP_TIMEOUT = 2'b11;

    // True while a transaction is waiting on the AXI slave.
    function automatic logic is_busy(input state_e s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
    endfunction

endpackage

// File: rtl/axi_lite_reg_master.sv
// Single-outstanding AXI4-Lite master: turns one command (read or write)
// into one AXI transaction and returns one response.
// Optional watchdog: define AXI_LITE_MASTER_TIMEOUT_EN to abort a stalled
// transaction after TIMEOUT_CYCLES busy cycles with rsp_err = 2'b11.
module axi_lite_reg_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      m00_axi_aclk,
    input  logic                      m00_axi_areset,
    // command / response side
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_err,
    // AXI4-Lite master port
    output logic [AXI_ADDR_WIDTH-1:0] m00_axi_awaddr,
    output logic                      m00_axi_awvalid,
    input  logic                      m00_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0] m00_axi_wdata,
    output logic                      m00_axi_wvalid,
    input  logic                      m00_axi_wready,
    input  logic [1:0]                m00_axi_bresp,
    input  logic                      m00_axi_bvalid,
    output logic                      m00_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic                      m00_axi_arvalid,
    input  logic                      m00_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                m00_axi_rresp,
    input  logic                      m00_axi_rvalid,
    output logic                      m00_axi_rready
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e                    state_q, state_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    resp_t                     rsp_err_q, rsp_err_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                      awvalid_q, awvalid_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      wvalid_q, wvalid_d;
    logic                      bready_q, bready_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_write) begin
                        state_d   = WR_REQ;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_REQ;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each valid drops after its own handshake.
                if (awvalid_q && m00_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m00_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m00_axi_bvalid) begin
                    state_d     = DONE;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = m00_axi_bresp;
                end
            end
            RD_REQ: begin
                if (m00_axi_arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (m00_axi_rvalid) begin
                    state_d     = DONE;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m00_axi_rdata;
                    rsp_err_d   = m00_axi_rresp;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // Watchdog: a real completion in the final cycle still wins over the timeout.
        to_cnt_d = '0;
        if (is_busy(state_q)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (state_d != DONE && to_cnt_q == TO_LAST) begin
                state_d     = DONE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = RESP_TIMEOUT;
            end
        end
`endif

        cmd_ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= RESP_OKAY;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign m00_axi_awaddr  = awaddr_q;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

endmodule
